debounce_edge_multi: RTL and testbench

Parametrised N-channel debouncer and edge-pulse generator, the successor to the single-channel rising-edge pulser used behind the keyboard/button inputs of the odd/even game. Each channel synchronises a raw asynchronous input and filters it with a stable-count counter. It then outputs a clean debounced level plus a one-cycle pulse on the configured edge(s). An optional auto-repeat mode is compiled in by macro. It sits between board pins/keyboard decode and the processor's memory-mapped input registers.

---
 rtl/debounce_edge_multi.sv | 127 ++++++++++++
 tb/tb_debounce_edge_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/debounce_edge_multi.sv
// N-channel debouncer: 2-flop sync, stable counter, registered level and edge pulse.
// Optional auto-repeat on held presses is built only when DEBOUNCE_REPEAT_EN is defined.

module debounce_lane #(
    parameter int STABLE        = 16,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic pulse,
    output logic rpt
);
    localparam int CW = (STABLE > 1) ? $clog2(STABLE) : 1;

    if (STABLE < 1 || EDGE_MODE < 0 || EDGE_MODE > 2 ||
        REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_err
        $error("debounce_lane: illegal parameter value");
    end

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          flip;
    logic          edge_hit;
    logic          rep_fire;

    // s2 has disagreed with level for STABLE consecutive samples
    assign flip = (s2 != level) && (cnt == CW'(STABLE - 1));

    always_comb begin
        edge_hit = 1'b1;
        if (EDGE_MODE == 0)
            edge_hit = s2;
        else if (EDGE_MODE == 1)
            edge_hit = ~s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            s1    <= din;
            s2    <= s1;
            pulse <= (flip & edge_hit) | rep_fire;
            if (s2 == level) begin
                cnt <= '0;
            end else if (flip) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DEBOUNCE_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    logic [RW-1:0] rcnt;
    logic          rarm;  // first repeat already issued; later ones use the period
    logic [RW-1:0] rtgt;

    assign rtgt     = rarm ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
    assign rep_fire = (EDGE_MODE != 1) && level && !flip && (rcnt == rtgt);

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            rarm <= 1'b0;
            rpt  <= 1'b0;
        end else begin
            rpt <= rep_fire;
            if (flip || !level) begin
                rcnt <= '0;
                rarm <= 1'b0;
            end else if (rep_fire) begin
                rcnt <= '0;
                rarm <= 1'b1;
            end else begin
                rcnt <= rcnt + 1'b1;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
    assign rpt      = 1'b0;
`endif
endmodule

module debounce_edge_multi #(
    parameter int N             = 4,
    parameter int STABLE        = 16,
    parameter int EDGE_MODE     = 0,
    parameter int REPEAT_DELAY  = 1000,
    parameter int REPEAT_PERIOD = 200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] din,
    output logic [N-1:0] level,
    output logic [N-1:0] pulse,
    output logic [N-1:0] rpt
);
    for (genvar i = 0; i < N; i++) begin : g_lane
        debounce_lane #(
            .STABLE        (STABLE),
            .EDGE_MODE     (EDGE_MODE),
            .REPEAT_DELAY  (REPEAT_DELAY),
            .REPEAT_PERIOD (REPEAT_PERIOD)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .din   (din[i]),
            .level (level[i]),
            .pulse (pulse[i]),
            .rpt   (rpt[i])
        );
    end
endmodule

// File: tb/tb_debounce_edge_multi.sv
// Bench for debounce_edge_multi: three configurations share one stimulus stream and are
// compared each cycle against a sample-history reference model.

module tb_debounce_edge_multi;
    localparam int N  = 4;
    localparam int ND = 3;
    localparam int RD = 10;
    localparam int RP = 4;
`ifdef DEBOUNCE_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] din = '0;
    logic [N-1:0] lv [ND];
    logic [N-1:0] pu [ND];
    logic [N-1:0] rp [ND];

    always #5 clk = ~clk;

    debounce_edge_multi #(.N(N), .STABLE(4), .EDGE_MODE(0), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        u_dut0 (.clk(clk), .rst(rst), .din(din), .level(lv[0]), .pulse(pu[0]), .rpt(rp[0]));
    debounce_edge_multi #(.N(N), .STABLE(4), .EDGE_MODE(1), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        u_dut1 (.clk(clk), .rst(rst), .din(din), .level(lv[1]), .pulse(pu[1]), .rpt(rp[1]));
    debounce_edge_multi #(.N(N), .STABLE(8), .EDGE_MODE(2), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP))
        u_dut2 (.clk(clk), .rst(rst), .din(din), .level(lv[2]), .pulse(pu[2]), .rpt(rp[2]));

    function automatic int stb(input int d);
        return (d == 2) ? 8 : 4;
    endfunction

    // Reference: raw[c] holds din as seen at past edges (bit 0 = previous edge).
    // Level flips when the STABLE samples that have cleared the synchroniser all differ from it.
    logic [63:0]  raw [N];
    bit           mlv [ND][N];
    int           pedge [ND][N];
    int           ecnt;
    logic [N-1:0] exp_lv [ND];
    logic [N-1:0] exp_pu [ND];
    logic [N-1:0] exp_rp [ND];
    int           checks = 0;
    int           errors = 0;

    task automatic model_edge();
        for (int c = 0; c < N; c++) begin
            for (int d = 0; d < ND; d++) begin
                logic [63:0] mask, win;
                bit flip;
                if (rst) begin
                    mlv[d][c] = 1'b0;
                    exp_lv[d][c] = 1'b0;
                    exp_pu[d][c] = 1'b0;
                    exp_rp[d][c] = 1'b0;
                    continue;
                end
                mask = (64'd1 << stb(d)) - 64'd1;
                win  = (raw[c] >> 1) & mask;
                flip = mlv[d][c] ? (win == 64'd0) : (win == mask);
                exp_pu[d][c] = 1'b0;
                exp_rp[d][c] = 1'b0;
                if (flip) begin
                    mlv[d][c] = !mlv[d][c];
                    if (mlv[d][c]) pedge[d][c] = ecnt;
                    exp_pu[d][c] = (d == 2) || (d == 0 && mlv[d][c]) || (d == 1 && !mlv[d][c]);
                end else if (REP && mlv[d][c] && d != 1 && (ecnt - pedge[d][c]) >= RD &&
                             ((ecnt - pedge[d][c] - RD) % RP) == 0) begin
                    exp_pu[d][c] = 1'b1;
                    exp_rp[d][c] = 1'b1;
                end
                exp_lv[d][c] = mlv[d][c];
            end
            raw[c] = rst ? 64'd0 : {raw[c][62:0], din[c]};
        end
        ecnt++;
    endtask

    task automatic lit(input string tag, input logic [N-1:0] got, input logic [N-1:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        for (int d = 0; d < ND; d++) begin
            lit($sformatf("level%0d@%0d", d, ecnt), lv[d], exp_lv[d]);
            lit($sformatf("pulse%0d@%0d", d, ecnt), pu[d], exp_pu[d]);
            lit($sformatf("rpt%0d@%0d", d, ecnt), rp[d], exp_rp[d]);
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        ecnt = 0;
        for (int c = 0; c < N; c++) raw[c] = 64'd0;
        for (int d = 0; d < ND; d++)
            for (int c = 0; c < N; c++) begin
                mlv[d][c] = 1'b0;
                pedge[d][c] = 0;
            end

        // reset state
        rst = 1'b1; din = '0;
        steps(2);
        lit("reset_level", lv[0], 4'b0000);
        lit("reset_pulse", pu[0], 4'b0000);
        rst = 1'b0;
        steps(3);

        // clean press on channel 0: edges 0..4 quiet, level+pulse after edge 5
        din = 4'b0001;
        steps(5);
        lit("press_early", lv[0], 4'b0000);
        step();
        lit("press_level", lv[0], 4'b0001);
        lit("press_pulse", pu[0], 4'b0001);
        step();
        lit("press_pulse_end", pu[0], 4'b0000);
        lit("press_level_hold", lv[0], 4'b0001);

        // glitch on channel 1 shorter than STABLE
        din[1] = 1'b1;
        steps(3);
        din[1] = 1'b0;
        steps(20);
        lit("glitch_level", lv[0], 4'b0001);

        // repeat window while channel 0 is held, then release
        steps(30);
        din = 4'b0000;
        steps(20);

        // all channels together: rise, hold 30, fall
        din = 4'b1111;
        steps(30);
        din = 4'b0000;
        steps(30);

        // reset in the middle of a count on channel 2
        din[2] = 1'b1;
        steps(4);
        rst = 1'b1;
        step();
        lit("midreset_level", lv[0], 4'b0000);
        rst = 1'b0;
        steps(20);
        lit("midreset_after", lv[0], 4'b0100);
        din = 4'b0000;
        steps(20);

        // random stimulus with occasional resets
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 11) == 0) din[c] = ~din[c];
            rst = ($urandom_range(0, 499) == 0);
            step();
        end
        rst = 1'b0;
        din = '0;
        steps(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
